// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// isa package and mem_port_arbiter_if
//
// isa          : machine width (XLEN) and the load/store access-width type
//                shared by the pipeline and the memory port arbiter.
// mem_port_arbiter_if : bundles the three buses around the arbiter.
//   fetch side   : fi_rd_enable, fi_addr        -> fo_miss, fo_rd_data
//   data side    : di_rd_enable, di_wr_enable, di_addr, di_wr_data,
//                  di_access_type               -> do_miss, do_rd_data
//   backing side : bo_req, bo_we, bo_addr, bo_wr_data, bo_byte_en
//                                               <- bi_ack, bi_rd_data
//   modport master : the arbiter (it masters the backing bus)
//   modport slave  : the surrounding pipeline stages and backing memory
// ---------------------------------------------------------------------------
package isa;
    parameter int XLEN = 32;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } mem_access_t;
endpackage

interface mem_port_arbiter_if;
    import isa::*;

    // fetch stage read port
    logic                fi_rd_enable;
    logic [XLEN-1:0]     fi_addr;
    logic                fo_miss;
    logic [XLEN-1:0]     fo_rd_data;

    // memory stage data port
    logic                di_rd_enable;
    logic                di_wr_enable;
    logic [XLEN-1:0]     di_addr;
    logic [XLEN-1:0]     di_wr_data;
    mem_access_t         di_access_type;
    logic                do_miss;
    logic [XLEN-1:0]     do_rd_data;

    // backing memory req/ack bus
    logic                bo_req;
    logic                bo_we;
    logic [XLEN-1:0]     bo_addr;
    logic [XLEN-1:0]     bo_wr_data;
    logic [XLEN/8-1:0]   bo_byte_en;
    logic                bi_ack;
    logic [XLEN-1:0]     bi_rd_data;

    modport master (
        input  fi_rd_enable, fi_addr,
        output fo_miss, fo_rd_data,
        input  di_rd_enable, di_wr_enable, di_addr, di_wr_data, di_access_type,
        output do_miss, do_rd_data,
        output bo_req, bo_we, bo_addr, bo_wr_data, bo_byte_en,
        input  bi_ack, bi_rd_data
    );

    modport slave (
        output fi_rd_enable, fi_addr,
        input  fo_miss, fo_rd_data,
        output di_rd_enable, di_wr_enable, di_addr, di_wr_data, di_access_type,
        input  do_miss, do_rd_data,
        input  bo_req, bo_we, bo_addr, bo_wr_data, bo_byte_en,
        output bi_ack, bi_rd_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one backing-memory port between instruction fetch and the memory
// stage. Requests are arbitrated in IDLE (data before fetch, store before
// load), issued on a registered req/ack bus, and the response is offered to
// the owner for one DONE cycle. The owner only completes if it is still
// asking for the same thing; otherwise the result is dropped and the request
// is re-arbitrated, so in-flight backing transactions are never aborted.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.master (fetch, data and backing buses)
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import isa::*;
(
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    localparam int BEW = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    // Byte offset within the word, with the bits below the access size
    // cleared so a misaligned address behaves like its aligned counterpart.
    function automatic logic [1:0] masked_offset(input mem_access_t t, input logic [1:0] a);
        logic [1:0] off;
        case (t)
            BYTE:      off = a;
            HALF_WORD: off = {a[1], 1'b0};
            WORD:      off = 2'b00;
            default:   off = 2'b00;
        endcase
        return off;
    endfunction

    // Write lane mask for an access of width t starting at an already masked offset.
    function automatic logic [BEW-1:0] byte_enables(input mem_access_t t, input logic [1:0] off);
        logic [BEW-1:0] be;
        case (t)
            BYTE:      be = BEW'(1'b1) << off;
            HALF_WORD: be = BEW'(2'b11) << off;
            WORD:      be = {BEW{1'b1}};
            default:   be = {BEW{1'b0}};
        endcase
        return be;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    owner_t            owner_r;

    logic              bo_req_r;
    logic              bo_we_r;
    logic [XLEN-1:0]   bo_addr_r;
    logic [XLEN-1:0]   bo_wr_data_r;
    logic [BEW-1:0]    bo_byte_en_r;
    logic [XLEN-1:0]   addr_r;
    mem_access_t       type_r;
    logic [XLEN-1:0]   rsp_r;

    logic              data_req_s;
    logic              grant_s;
    owner_t            grant_owner_s;
    logic              grant_we_s;
    logic [XLEN-1:0]   grant_addr_s;
    mem_access_t       grant_type_s;
    logic [XLEN-1:0]   grant_raw_wdata_s;
    logic [1:0]        grant_off_s;
    logic [BEW-1:0]    grant_be_s;
    logic [XLEN-1:0]   grant_wdata_s;

    logic [1:0]        rd_off_s;
    logic              fetch_match_s;
    logic              data_match_s;
    logic              complete_fetch_s;
    logic              complete_data_s;

    assign data_req_s = bus.di_rd_enable | bus.di_wr_enable;
    assign grant_s    = (state_r == IDLE) & (data_req_s | bus.fi_rd_enable);

    // Grant selection: data beats fetch; within data, a store beats a load.
    always_comb begin
        grant_owner_s     = FETCH;
        grant_we_s        = 1'b0;
        grant_addr_s      = bus.fi_addr;
        grant_type_s      = WORD;
        grant_raw_wdata_s = {XLEN{1'b0}};
        if (data_req_s) begin
            grant_owner_s     = DATA;
            grant_we_s        = bus.di_wr_enable;
            grant_addr_s      = bus.di_addr;
            grant_type_s      = bus.di_access_type;
            grant_raw_wdata_s = bus.di_wr_data;
        end else begin
            grant_owner_s     = FETCH;
        end
    end

    assign grant_off_s   = masked_offset(grant_type_s, grant_addr_s[1:0]);
    assign grant_be_s    = byte_enables(grant_type_s, grant_off_s);
    assign grant_wdata_s = grant_raw_wdata_s << {grant_off_s, 3'b000};

    // FSM next state: IDLE -> BUSY on grant, BUSY -> DONE on ack, DONE -> IDLE always.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (bus.bi_ack) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Transaction latch and response buffer; bo_* only change on grant so
    // they stay stable for the whole BUSY phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r      <= FETCH;
            bo_req_r     <= 1'b0;
            bo_we_r      <= 1'b0;
            bo_addr_r    <= {XLEN{1'b0}};
            bo_wr_data_r <= {XLEN{1'b0}};
            bo_byte_en_r <= {BEW{1'b0}};
            addr_r       <= {XLEN{1'b0}};
            type_r       <= BYTE;
            rsp_r        <= {XLEN{1'b0}};
        end else if (grant_s) begin
            owner_r      <= grant_owner_s;
            bo_req_r     <= 1'b1;
            bo_we_r      <= grant_we_s;
            bo_addr_r    <= {grant_addr_s[XLEN-1:2], 2'b00};
            bo_wr_data_r <= grant_wdata_s;
            bo_byte_en_r <= grant_be_s;
            addr_r       <= grant_addr_s;
            type_r       <= grant_type_s;
        end else if ((state_r == BUSY) && bus.bi_ack) begin
            bo_req_r     <= 1'b0;
            rsp_r        <= bus.bi_rd_data;
        end
    end

    // The owner still wants exactly what was issued: same enable, address and direction.
    assign fetch_match_s = bus.fi_rd_enable & (bus.fi_addr == addr_r);
    assign data_match_s  = data_req_s & (bus.di_addr == addr_r) & (bus.di_wr_enable == bo_we_r);

    assign complete_fetch_s = (state_r == DONE) & (owner_r == FETCH) & fetch_match_s;
    assign complete_data_s  = (state_r == DONE) & (owner_r == DATA) & data_match_s;

    assign rd_off_s = masked_offset(type_r, addr_r[1:0]);

    assign bus.fo_miss    = bus.fi_rd_enable & ~complete_fetch_s;
    assign bus.do_miss    = data_req_s & ~complete_data_s;
    assign bus.fo_rd_data = complete_fetch_s ? rsp_r : {XLEN{1'b0}};
    assign bus.do_rd_data = (complete_data_s & ~bo_we_r) ? (rsp_r >> {rd_off_s, 3'b000})
                                                         : {XLEN{1'b0}};

    assign bus.bo_req     = bo_req_r;
    assign bus.bo_we      = bo_we_r;
    assign bus.bo_addr    = bo_addr_r;
    assign bus.bo_wr_data = bo_wr_data_r;
    assign bus.bo_byte_en = bo_byte_en_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter: a table of single-owner transactions
// (request, ack delay, returned word, expected bus/lane/readback values),
// followed by hand sequences for reset with a pending fetch, simultaneous
// fetch/data requests, a fetch redirected while BUSY, and reset mid-BUSY.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import isa::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus_if ();

    mem_port_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic        fi_rd;
        logic [31:0] fi_addr;
        logic        di_rd;
        logic        di_wr;
        logic [31:0] di_addr;
        logic [31:0] di_wdata;
        mem_access_t di_type;
        int          ack_dly;
        logic [31:0] ack_data;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_frd;
        logic [31:0] exp_drd;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drop_requests();
        bus_if.fi_rd_enable = 1'b0;
        bus_if.di_rd_enable = 1'b0;
        bus_if.di_wr_enable = 1'b0;
    endtask

    // One transaction from an IDLE falling edge through DONE and back to IDLE.
    task automatic run_vec(input int i);
        vec_t v;
        logic is_data;
        v = vecs[i];
        is_data = v.di_rd | v.di_wr;
        bus_if.fi_rd_enable   = v.fi_rd;
        bus_if.fi_addr        = v.fi_addr;
        bus_if.di_rd_enable   = v.di_rd;
        bus_if.di_wr_enable   = v.di_wr;
        bus_if.di_addr        = v.di_addr;
        bus_if.di_wr_data     = v.di_wdata;
        bus_if.di_access_type = v.di_type;
        #1;
        chk($sformatf("v%0d.idle_miss", i), {31'd0, is_data ? bus_if.do_miss : bus_if.fo_miss}, 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d.bo_req", i), {31'd0, bus_if.bo_req}, 32'd1);
        chk($sformatf("v%0d.bo_addr", i), bus_if.bo_addr, v.exp_addr);
        chk($sformatf("v%0d.bo_we", i), {31'd0, bus_if.bo_we}, {31'd0, v.exp_we});
        chk($sformatf("v%0d.bo_byte_en", i), {28'd0, bus_if.bo_byte_en}, {28'd0, v.exp_be});
        chk($sformatf("v%0d.bo_wr_data", i), bus_if.bo_wr_data, v.exp_wdata);
        chk($sformatf("v%0d.busy_miss", i), {31'd0, is_data ? bus_if.do_miss : bus_if.fo_miss}, 32'd1);
        for (int d = 0; d < v.ack_dly; d++) begin
            @(negedge clk);
            chk($sformatf("v%0d.wait_req", i), {31'd0, bus_if.bo_req}, 32'd1);
        end
        bus_if.bi_ack     = 1'b1;
        bus_if.bi_rd_data = v.ack_data;
        @(negedge clk);
        bus_if.bi_ack     = 1'b0;
        bus_if.bi_rd_data = 32'hFFFF_FFFF;
        chk($sformatf("v%0d.done_miss", i), {31'd0, is_data ? bus_if.do_miss : bus_if.fo_miss}, 32'd0);
        chk($sformatf("v%0d.fo_rd_data", i), bus_if.fo_rd_data, v.exp_frd);
        chk($sformatf("v%0d.do_rd_data", i), bus_if.do_rd_data, v.exp_drd);
        chk($sformatf("v%0d.done_req", i), {31'd0, bus_if.bo_req}, 32'd0);
        drop_requests();
        @(negedge clk);
        chk($sformatf("v%0d.idle_req", i), {31'd0, bus_if.bo_req}, 32'd0);
    endtask

    initial begin
        //          fi_rd fi_addr     di_rd di_wr di_addr     di_wdata      type       dly ack_data        exp_addr    we    be       wdata          frd            drd
        vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h000, 32'h0000_0000, WORD,      0, 32'hDEAD_BEEF, 32'h100, 1'b0, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h000, 1'b0, 1'b1, 32'h103, 32'h0000_00A5, BYTE,      0, 32'h1111_1111, 32'h100, 1'b1, 4'b1000, 32'hA500_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{1'b0, 32'h000, 1'b0, 1'b1, 32'h102, 32'h0000_1234, HALF_WORD, 1, 32'h2222_2222, 32'h100, 1'b1, 4'b1100, 32'h1234_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h206, 32'h0000_0000, HALF_WORD, 0, 32'hBEEF_0000, 32'h204, 1'b0, 4'b1100, 32'h0000_0000, 32'h0000_0000, 32'h0000_BEEF};
        vecs[4] = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h400, 32'h0000_0000, WORD,      2, 32'hCAFE_F00D, 32'h400, 1'b0, 4'b1111, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h401, 32'h0000_0000, BYTE,      0, 32'h1122_3344, 32'h400, 1'b0, 4'b0010, 32'h0000_0000, 32'h0000_0000, 32'h0011_2233};
        vecs[6] = '{1'b0, 32'h000, 1'b0, 1'b1, 32'h502, 32'h89AB_CDEF, WORD,      0, 32'h3333_3333, 32'h500, 1'b1, 4'b1111, 32'h89AB_CDEF, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{1'b0, 32'h000, 1'b0, 1'b1, 32'h603, 32'h0000_BEAD, HALF_WORD, 0, 32'h4444_4444, 32'h600, 1'b1, 4'b1100, 32'hBEAD_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h700, 32'h0000_005A, BYTE,      0, 32'h5555_5555, 32'h700, 1'b1, 4'b0001, 32'h0000_005A, 32'h0000_0000, 32'h0000_0000};
        vecs[9] = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h7FF, 32'h0000_0000, BYTE,      1, 32'hAB00_0000, 32'h7FC, 1'b0, 4'b1000, 32'h0000_0000, 32'h0000_0000, 32'h0000_00AB};

        // reset with a fetch already pending
        rst                   = 1'b1;
        bus_if.fi_rd_enable   = 1'b1;
        bus_if.fi_addr        = 32'h100;
        bus_if.di_rd_enable   = 1'b0;
        bus_if.di_wr_enable   = 1'b0;
        bus_if.di_addr        = 32'h0;
        bus_if.di_wr_data     = 32'h0;
        bus_if.di_access_type = WORD;
        bus_if.bi_ack         = 1'b0;
        bus_if.bi_rd_data     = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst.bo_req", {31'd0, bus_if.bo_req}, 32'd0);
        chk("rst.bo_we", {31'd0, bus_if.bo_we}, 32'd0);
        chk("rst.bo_addr", bus_if.bo_addr, 32'h0);
        chk("rst.bo_wr_data", bus_if.bo_wr_data, 32'h0);
        chk("rst.bo_byte_en", {28'd0, bus_if.bo_byte_en}, 32'd0);
        chk("rst.fo_rd_data", bus_if.fo_rd_data, 32'h0);
        chk("rst.do_rd_data", bus_if.do_rd_data, 32'h0);
        chk("rst.fo_miss", {31'd0, bus_if.fo_miss}, 32'd1);
        chk("rst.do_miss", {31'd0, bus_if.do_miss}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // simultaneous fetch 0x200 and load WORD 0x400: data first, fetch next
        bus_if.fi_rd_enable   = 1'b1;
        bus_if.fi_addr        = 32'h200;
        bus_if.di_rd_enable   = 1'b1;
        bus_if.di_addr        = 32'h400;
        bus_if.di_access_type = WORD;
        @(negedge clk);
        chk("sim.bo_addr1", bus_if.bo_addr, 32'h400);
        chk("sim.fo_miss_busy", {31'd0, bus_if.fo_miss}, 32'd1);
        bus_if.bi_ack = 1'b1; bus_if.bi_rd_data = 32'h1234_5678;
        @(negedge clk);
        bus_if.bi_ack = 1'b0;
        chk("sim.do_miss_done", {31'd0, bus_if.do_miss}, 32'd0);
        chk("sim.do_rd_data", bus_if.do_rd_data, 32'h1234_5678);
        chk("sim.fo_miss_done", {31'd0, bus_if.fo_miss}, 32'd1);
        chk("sim.fo_rd_data0", bus_if.fo_rd_data, 32'h0);
        bus_if.di_rd_enable = 1'b0;
        @(negedge clk);
        chk("sim.idle_req", {31'd0, bus_if.bo_req}, 32'd0);
        @(negedge clk);
        chk("sim.bo_req2", {31'd0, bus_if.bo_req}, 32'd1);
        chk("sim.bo_addr2", bus_if.bo_addr, 32'h200);
        bus_if.bi_ack = 1'b1; bus_if.bi_rd_data = 32'h0BAD_F00D;
        @(negedge clk);
        bus_if.bi_ack = 1'b0;
        chk("sim.fo_miss_fetch", {31'd0, bus_if.fo_miss}, 32'd0);
        chk("sim.fo_rd_data", bus_if.fo_rd_data, 32'h0BAD_F00D);
        drop_requests();
        @(negedge clk);

        // fetch 0x300 redirected to 0x340 while BUSY, ack delayed 4 cycles
        bus_if.fi_rd_enable = 1'b1;
        bus_if.fi_addr      = 32'h300;
        @(negedge clk);
        chk("redir.bo_addr", bus_if.bo_addr, 32'h300);
        bus_if.fi_addr = 32'h340;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            chk("redir.hold_req", {31'd0, bus_if.bo_req}, 32'd1);
            chk("redir.hold_addr", bus_if.bo_addr, 32'h300);
            chk("redir.hold_miss", {31'd0, bus_if.fo_miss}, 32'd1);
        end
        bus_if.bi_ack = 1'b1; bus_if.bi_rd_data = 32'h3030_3030;
        @(negedge clk);
        bus_if.bi_ack = 1'b0;
        chk("redir.done_miss", {31'd0, bus_if.fo_miss}, 32'd1);
        chk("redir.done_data", bus_if.fo_rd_data, 32'h0);
        @(negedge clk);
        chk("redir.idle_req", {31'd0, bus_if.bo_req}, 32'd0);
        @(negedge clk);
        chk("redir.new_req", {31'd0, bus_if.bo_req}, 32'd1);
        chk("redir.new_addr", bus_if.bo_addr, 32'h340);
        bus_if.bi_ack = 1'b1; bus_if.bi_rd_data = 32'h3434_3434;
        @(negedge clk);
        bus_if.bi_ack = 1'b0;
        chk("redir.new_miss", {31'd0, bus_if.fo_miss}, 32'd0);
        chk("redir.new_data", bus_if.fo_rd_data, 32'h3434_3434);
        drop_requests();
        @(negedge clk);

        // reset while BUSY; a late ack must not advance the FSM
        bus_if.fi_rd_enable = 1'b1;
        bus_if.fi_addr      = 32'h800;
        @(negedge clk);
        chk("mrst.busy_req", {31'd0, bus_if.bo_req}, 32'd1);
        rst = 1'b1;
        bus_if.fi_rd_enable = 1'b0;
        @(negedge clk);
        chk("mrst.req", {31'd0, bus_if.bo_req}, 32'd0);
        chk("mrst.addr", bus_if.bo_addr, 32'h0);
        rst = 1'b0;
        bus_if.bi_ack = 1'b1; bus_if.bi_rd_data = 32'h8888_8888;
        @(negedge clk);
        bus_if.bi_ack = 1'b0;
        chk("mrst.late_ack_req", {31'd0, bus_if.bo_req}, 32'd0);
        chk("mrst.late_ack_data", bus_if.fo_rd_data, 32'h0);
        bus_if.fi_rd_enable = 1'b1;
        bus_if.fi_addr      = 32'h900;
        @(negedge clk);
        chk("mrst.regrant_req", {31'd0, bus_if.bo_req}, 32'd1);
        chk("mrst.regrant_addr", bus_if.bo_addr, 32'h900);
        bus_if.bi_ack = 1'b1; bus_if.bi_rd_data = 32'h9999_0000;
        @(negedge clk);
        bus_if.bi_ack = 1'b0;
        chk("mrst.done_miss", {31'd0, bus_if.fo_miss}, 32'd0);
        chk("mrst.done_data", bus_if.fo_rd_data, 32'h9999_0000);
        drop_requests();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
